// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for one N_IN-input, 1-output combinational block.
// Drives every vector, samples after SETTLE extra cycles, tallies mismatches.
module truth_table_sweeper #(
    parameter int                 N_IN      = 5,
    parameter logic [2**N_IN-1:0] EXP_TABLE = 32'hCFC89F7F,
    parameter int                 SETTLE    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_count,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   captured_table
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] idx;
    logic [3:0]      hold;
    logic            sample;
    logic            last;
    logic            miss;
    logic [N_IN:0]   count_nxt;

    assign dut_in = idx;
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        sample    = (state == RUN) && !abort && (hold == 4'(SETTLE));
        last      = &idx;
        miss      = (dut_out != EXP_TABLE[idx]);
        count_nxt = mismatch_count + {{N_IN{1'b0}}, miss};
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (abort)              state_nxt = IDLE;
                else if (sample && last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            hold           <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail     <= '0;
            captured_table <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx            <= '0;
                        hold           <= '0;
                        pass           <= 1'b0;
                        mismatch_count <= '0;
                        fail_valid     <= 1'b0;
                        first_fail     <= '0;
                        captured_table <= '0;
                    end
                end
                RUN: begin
                    // abort wins over a coinciding sample; that sample is dropped
                    if (abort) begin
                        idx  <= '0;
                        hold <= '0;
                    end else if (sample) begin
                        captured_table[idx] <= dut_out;
                        if (miss) begin
                            mismatch_count <= count_nxt;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= idx;
                            end
                        end
                        hold <= '0;
                        if (last) pass <= (count_nxt == '0);
                        else      idx  <= idx + 1'b1;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper (SETTLE=0 and SETTLE=3).
// Reference results come from table arithmetic, not from the FSM.
module tb_truth_table_sweeper;

    localparam logic [31:0] EXP = 32'hCFC89F7F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        sel;
    logic [31:0] mdl;

    logic        start0, abort0, out0, busy0, done0, pass0, fv0;
    logic        start3, abort3, out3, busy3, done3, pass3, fv3;
    logic [4:0]  in0, ff0, in3, ff3;
    logic [5:0]  mc0, mc3;
    logic [31:0] ct0, ct3;

    logic        busy, done, pass, fv;
    logic [4:0]  din, ff;
    logic [5:0]  mc;
    logic [31:0] ct;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign abort0 = abort & ~sel;
    assign start3 = start & sel;
    assign abort3 = abort & sel;
    assign out0   = mdl[in0];
    assign out3   = mdl[in3];

    assign busy = sel ? busy3 : busy0;
    assign done = sel ? done3 : done0;
    assign pass = sel ? pass3 : pass0;
    assign fv   = sel ? fv3   : fv0;
    assign din  = sel ? in3   : in0;
    assign ff   = sel ? ff3   : ff0;
    assign mc   = sel ? mc3   : mc0;
    assign ct   = sel ? ct3   : ct0;

    truth_table_sweeper #(.N_IN(5), .EXP_TABLE(EXP), .SETTLE(0)) u_s0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
        .dut_in(in0), .dut_out(out0), .busy(busy0), .done(done0),
        .pass(pass0), .mismatch_count(mc0), .fail_valid(fv0),
        .first_fail(ff0), .captured_table(ct0)
    );

    truth_table_sweeper #(.N_IN(5), .EXP_TABLE(EXP), .SETTLE(3)) u_s3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .abort(abort3),
        .dut_in(in3), .dut_out(out3), .busy(busy3), .done(done3),
        .pass(pass3), .mismatch_count(mc3), .fail_valid(fv3),
        .first_fail(ff3), .captured_table(ct3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_mc"}, mc, 0);
        chk({tag, "_fv"}, fv, 0);
        chk({tag, "_ff"}, ff, 0);
        chk({tag, "_ct"}, ct, 0);
        chk({tag, "_din"}, din, 0);
    endtask

    // One sweep; ab = edge (after start edge) carrying abort, 0 = none
    task automatic sweep(input logic s, input logic [31:0] m, input int ab);
        int          st;
        int          tot;
        int          ns;
        int          exp_mc;
        int          exp_ff;
        logic [31:0] msk;
        logic [31:0] diff;
        logic        exp_pass;
        st  = s ? 3 : 0;
        tot = 32 * (st + 1);
        @(negedge clk);
        sel   = s;
        mdl   = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_din", din, 0);
        chk("start_pass", pass, 0);
        chk("start_mc", mc, 0);
        chk("start_fv", fv, 0);
        chk("start_ct", ct, 0);
        for (int k = 1; k <= tot; k++) begin
            @(negedge clk);
            abort = (k == ab);
            @(posedge clk);
            #1;
            abort = 1'b0;
            if (k == ab) begin
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_din", din, 0);
                break;
            end
            if (k < tot) begin
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_din", din, k / (st + 1));
            end else begin
                chk("end_done", done, 1);
                chk("end_busy", busy, 0);
            end
        end
        ns       = (ab != 0) ? (ab - 1) / (st + 1) : 32;
        msk      = (ns >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ns) - 32'd1);
        diff     = (m ^ EXP) & msk;
        exp_mc   = $countones(diff);
        exp_ff   = 0;
        for (int i = 31; i >= 0; i--)
            if (diff[i]) exp_ff = i;
        exp_pass = (ab == 0) && (exp_mc == 0);
        chk("res_ct", ct, m & msk);
        chk("res_mc", mc, exp_mc);
        chk("res_fv", fv, diff != 0);
        chk("res_ff", ff, exp_ff);
        chk("res_pass", pass, exp_pass);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            abort = (k == 0);
            @(posedge clk);
            #1;
            abort = 1'b0;
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_pass", pass, exp_pass);
            chk("idle_mc", mc, exp_mc);
        end
    endtask

    initial begin
        int dones;
        int s;
        int ab;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        sel     = 1'b0;
        mdl     = EXP;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst0");
        sel = 1'b1;
        #1;
        chk_zero("rst3");
        @(negedge clk);
        reset_n = 1'b1;

        sweep(1'b0, EXP, 0);
        sweep(1'b0, EXP ^ 32'h0002_0008, 0);
        sweep(1'b1, 32'h0, 0);
        sweep(1'b0, EXP, 10);
        sweep(1'b0, EXP ^ 32'h8000_0000, 0);
        sweep(1'b0, EXP ^ 32'h0000_0001, 32);

        // reset in the middle of a sweep
        @(negedge clk);
        sel   = 1'b0;
        mdl   = EXP ^ 32'h0000_00F0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        sweep(1'b0, EXP, 0);

        // start held high: one done every 34 cycles, no restart while busy
        dones = 0;
        @(negedge clk);
        sel   = 1'b0;
        mdl   = EXP;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk);
            #1;
            chk("held_done", done, (k % 34) == 32);
            chk("held_busy", busy, (k % 34) < 32);
            if (done) dones++;
        end
        chk("held_count", dones, 3);
        @(negedge clk);
        start = 1'b0;

        for (int r = 0; r < 12; r++) begin
            s  = int'($urandom_range(0, 1));
            ab = 0;
            if ($urandom_range(0, 1) == 1)
                ab = int'($urandom_range(1, 32 * (s * 3 + 1)));
            sweep(s[0], EXP ^ ($urandom & $urandom & $urandom), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
